mem_access_unit: RTL and testbench

Byte-addressed RV32I load/store front end for the 32-bit word-wide data RAM. It accepts one load or store request at a time from the core's memory stage and translates it into word-granular RAM read/write strobes. Because the RAM has no byte enables, sub-word stores are done as read-modify-write. Load data is aligned and sign- or zero-extended before it is returned to the core.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_access_unit_load_align.sv | 38 +++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access path: funct3 encodings,
// the access-unit state enum and the RAM size shared with the RAM macro.
`timescale 1ns/1ps
package mem_pkg;

  localparam int DEFAULT_MEM_WORDS = 2048;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    LD,
    MERGE,
    WR,
    ERR
  } mau_state_t;

  // Stores only have B/H/W. Loads add the unsigned B/H variants.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3 > F3_W;
    else    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Picks the addressed byte/halfword lane out of a RAM word and extends it
// to 32 bits according to the load funct3.
`timescale 1ns/1ps
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Select the lane, then sign- or zero-extend it.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    byte_sel = word[7:0];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase

    data = word;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV32I load/store front end for a word-wide RAM without byte enables.
// Sub-word stores are done as read-modify-write; loads are lane-aligned
// and extended before being returned.
`timescale 1ns/1ps
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              ram_wen,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  mau_state_t        state, state_nxt;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] idx_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;

  logic [ADDR_W-1:0] req_idx;
  logic              accept;
  logic              align_bad;
  logic              range_bad;
  logic              req_err;
  logic [31:0]       load_data;
  logic [31:0]       merge_mask;
  logic [31:0]       merge_ins;
  logic [31:0]       merge_word;

  assign req_idx   = req_addr[ADDR_W+1:2];
  assign accept    = req_valid && (state == IDLE);
  assign align_bad = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign range_bad = (|req_addr[31:ADDR_W+2]) || (32'(req_idx) >= 32'(MEM_WORDS));
  assign req_err   = f3_illegal(req_we, req_funct3) || align_bad || range_bad;

  load_align u_load_align (
    .word   (ram_rdata),
    .lane   (lane_q),
    .funct3 (f3_q),
    .data   (load_data)
  );

  // Sub-word store: overwrite only the addressed lane of the word just read.
  assign merge_mask = (f3_q == F3_B) ? (32'h0000_00FF << {lane_q, 3'b000})
                                     : (32'h0000_FFFF << {lane_q[1], 4'b0000});
  assign merge_ins  = (f3_q == F3_B) ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
  assign merge_word = (ram_rdata & ~merge_mask) | (merge_ins & merge_mask);

  // Both RAM addresses always show the latched word index.
  assign ram_raddr = idx_q;
  assign ram_waddr = idx_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Capture the request on accept; cleared by reset so addresses read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      idx_q   <= '0;
      lane_q  <= 2'b00;
      wdata_q <= 32'h0;
    end else if (accept) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      idx_q   <= req_idx;
      lane_q  <= req_addr[1:0];
      wdata_q <= req_wdata;
    end
  end

  // Next-state and all outputs, decoded from the current state.
  always_comb begin
    state_nxt = state;
    req_ready = (state == IDLE) && !rst;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                              state_nxt = ERR;
          else if (req_we && (req_funct3 == F3_W))  state_nxt = WR;
          else                                      state_nxt = RD;
        end
      end
      RD: begin
        ram_ren   = 1'b1;
        state_nxt = we_q ? MERGE : LD;
      end
      LD: begin
        rsp_valid = 1'b1;
        rsp_rdata = load_data;
        state_nxt = IDLE;
      end
      MERGE: begin
        ram_wen   = 1'b1;
        ram_wdata = merge_word;
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      WR: begin
        ram_wen   = 1'b1;
        ram_wdata = wdata_q;
        rsp_valid = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a word RAM model, a byte-level
// reference model, directed timing checks and a randomized request stream.
`timescale 1ns/1ps
module tb_mem_access_unit;

  localparam int ADDR_W    = 16;
  localparam int MEM_WORDS = 2048;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100;

  logic              clk, rst;
  logic              req_valid, req_ready, req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic              ram_wen, ram_ren;
  logic [ADDR_W-1:0] ram_waddr, ram_raddr;
  logic [31:0]       ram_wdata, ram_rdata;

  mem_access_unit #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr),
    .ram_raddr(ram_raddr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word RAM the DUT drives: one-cycle read latency, write on the edge.
  logic [31:0] ram [MEM_WORDS];
  always @(posedge clk) begin
    if (ram_wen) ram[ram_waddr] = ram_wdata;
    if (ram_ren) ram_rdata <= ram[ram_raddr];
  end

  // Reference memory, updated as requests are issued.
  logic [31:0] ref_mem [MEM_WORDS];

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte-level behaviour of an RV32I access against a flat word memory.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    logic        legal;
    int          size, lane;
    logic [31:0] w, v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    lane  = int'(addr[1:0]);
    e.rdata = 32'h0;
    e.err   = !legal || ((addr % size) != 0) || ((addr >> 2) >= 32'(MEM_WORDS));
    if (e.err) return e;
    w = ref_mem[addr >> 2];
    if (we) begin
      for (int i = 0; i < size; i++) w[8*(lane+i) +: 8] = wd[8*i +: 8];
      ref_mem[addr >> 2] = w;
    end else begin
      v = w >> (8 * lane);
      if (size == 1)      e.rdata = f3[2] ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      else if (size == 2) e.rdata = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else                e.rdata = w;
    end
    return e;
  endfunction

  // Monitor: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", {31'h0, rsp_valid}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, mon_e.err});
      end
    end
  end

  task automatic preload(input int idx, input logic [31:0] val);
    ram[idx]     = val;
    ref_mem[idx] = val;
  endtask

  // Wait for ready, present one request for one accepting edge.
  // Returns #1 after the accepting edge (inside cycle N+1).
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit track);
    int n = 0;
    while (req_ready !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        check("ready_timeout", {31'h0, req_ready}, 32'h1);
        return;
      end
    end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    if (track) sb.push_back(model(we, f3, addr, wd));
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0) || (req_ready !== 1'b1)) begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        check("drain_timeout", sb.size(), 32'h0);
        return;
      end
    end
  endtask

  task automatic load_direct(input string name, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'h0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check(name, rsp_rdata, exp);
    drain();
  endtask

  logic        b2b_we   [3] = '{1'b1, 1'b0, 1'b1};
  logic [2:0]  b2b_f3   [3] = '{W, W, B};
  logic [31:0] b2b_addr [3] = '{32'h18, 32'h18, 32'h1A};
  logic [31:0] b2b_wd   [3] = '{32'hCAFE_F00D, 32'h0, 32'h0000_0077};

  initial begin
    int acc;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    for (int i = 0; i < MEM_WORDS; i++) preload(i, (i < 16) ? $urandom() : 32'h0);

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_strobes", {30'h0, ram_wen, ram_ren}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_ram_wdata", ram_wdata, 32'h0);
    check("rst_addrs", {ram_waddr, ram_raddr}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'h0, req_ready}, 32'h1);

    // LW timing.
    preload(4, 32'hDEAD_BEEF);
    issue(1'b0, W, 32'h10, 32'h0, 1'b1);
    @(negedge clk);
    check("lw_ren_n1", {31'h0, ram_ren}, 32'h1);
    check("lw_raddr_n1", 32'(ram_raddr), 32'h4);
    check("lw_no_rsp_n1", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    check("lw_rsp_n2", {31'h0, rsp_valid}, 32'h1);
    check("lw_rdata_n2", rsp_rdata, 32'hDEAD_BEEF);
    @(negedge clk);
    check("lw_ready_n3", {31'h0, req_ready}, 32'h1);

    // Sign/zero extension.
    preload(4, 32'h80FF_7F01);
    load_direct("lb_13", B, 32'h13, 32'hFFFF_FF80);
    load_direct("lbu_13", BU, 32'h13, 32'h0000_0080);
    load_direct("lh_12", H, 32'h12, 32'hFFFF_80FF);

    // SB read-modify-write.
    preload(4, 32'h1122_3344);
    issue(1'b1, B, 32'h11, 32'h0000_00AB, 1'b1);
    @(negedge clk);
    check("sb_ren_n1", {30'h0, ram_ren, ram_wen}, 32'h2);
    @(negedge clk);
    check("sb_wen_n2", {31'h0, ram_wen}, 32'h1);
    check("sb_waddr_n2", 32'(ram_waddr), 32'h4);
    check("sb_wdata_n2", ram_wdata, 32'h1122_AB44);
    drain();
    load_direct("lw_after_sb", W, 32'h10, 32'h1122_AB44);

    // Errors: misaligned SH, word index past the populated RAM.
    issue(1'b1, H, 32'h13, 32'h0000_5678, 1'b1);
    @(negedge clk);
    check("sh_mis_err", {30'h0, rsp_valid, rsp_err}, 32'h3);
    check("sh_mis_nostrobe", {30'h0, ram_wen, ram_ren}, 32'h0);
    drain();
    issue(1'b0, W, 32'h2000, 32'h0, 1'b1);
    @(negedge clk);
    check("lw_oor_err", {30'h0, rsp_valid, rsp_err}, 32'h3);
    check("lw_oor_nostrobe", {30'h0, ram_wen, ram_ren}, 32'h0);
    drain();
    issue(1'b1, W, 32'h1FFC, 32'h1234_5678, 1'b1);
    issue(1'b0, W, 32'h1FFC, 32'h0, 1'b1);
    drain();

    // Back-to-back SW, LW, SB with req_valid held high.
    @(negedge clk);
    acc = 0;
    req_we = b2b_we[0]; req_funct3 = b2b_f3[0]; req_addr = b2b_addr[0];
    req_wdata = b2b_wd[0]; req_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bit accepted;
      check("b2b_ready", {31'h0, req_ready}, 32'((c == 0) || (c == 2) || (c == 5)));
      accepted = (req_ready === 1'b1) && (acc < 3);
      if (accepted) sb.push_back(model(req_we, req_funct3, req_addr, req_wdata));
      @(posedge clk);
      #1;
      if (accepted) begin
        acc++;
        if (acc < 3) begin
          req_we = b2b_we[acc]; req_funct3 = b2b_f3[acc];
          req_addr = b2b_addr[acc]; req_wdata = b2b_wd[acc];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();

    // Reset during the MERGE of an SB: no write, no response.
    preload(5, 32'hA5A5_A5A5);
    issue(1'b1, B, 32'h15, 32'h0000_003C, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rstm_strobes", {29'h0, ram_wen, ram_ren, rsp_valid}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rstm_ready", {31'h0, req_ready}, 32'h1);
    check("rstm_ram5", ram[5], 32'hA5A5_A5A5);
    issue(1'b0, W, 32'h14, 32'h0, 1'b1);
    drain();

    // Randomized stream, mostly over words 0..15 so loads see earlier stores.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, 63));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom(), 1'b1);
    end
    drain();

    for (int i = 0; i < 16; i++) check("final_mem", ram[i], ref_mem[i]);
    check("final_mem_top", ram[MEM_WORDS-1], ref_mem[MEM_WORDS-1]);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
